anita4_scaler_reader: RTL and testbench

Sequencer on the reading side of the TURF scaler readout port. On each PPS it walks the scaler address map: 32 L2/L3 words plus 4 aux words. For each address it drives `scal_addr_o`, captures `scal_dat_i`, and emits a 37-word frame (header + 36 data) over a valid/ready stream toward the readout/housekeeping FIFO. It sits in the 33 MHz domain next to the scaler block, whose data output is combinational from the address.

---
 rtl/anita4_scaler_reader_if.sv | 31 +++
 rtl/anita4_scaler_reader.sv | 169 ++++++++++++++++
 tb/tb_anita4_scaler_reader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/anita4_scaler_reader_if.sv
// Scaler-readout bus: address/data toward the combinational scaler mux plus
// the valid/ready/last stream toward the readout FIFO.
interface anita4_scaler_reader_if;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] scal_addr;
  logic [DATA_W-1:0] scal_dat;
  logic [DATA_W-1:0] dat;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (
    output scal_addr,
    input  scal_dat,
    output dat,
    output valid,
    input  ready,
    output last
  );

  modport slave (
    input  scal_addr,
    output scal_dat,
    input  dat,
    input  valid,
    output ready,
    input  last
  );
endinterface

// File: rtl/anita4_scaler_reader.sv
// PPS-triggered sweep of the TURF scaler map: one header plus 36 scaler words
// per frame, streamed out over valid/ready.
module anita4_scaler_reader #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  HDR_TAG       = 8'h5C
) (
  input  logic                          clk33_i,
  input  logic                          rst_i,
  input  logic                          pps_i,
  input  logic                          enable_i,
  anita4_scaler_reader_if.master        bus,
  output logic                          busy_o,
  output logic                          overrun_o
);

  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned SEQ_W    = 16;
  localparam int unsigned NUM_DATA = 36;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_DATA - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_HDR,
    S_ADDR,
    S_PUSH
  } state_t;

  state_t              state, state_nxt;
  logic                pps_q;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [ADDR_W-1:0]   idx_q, idx_nxt;
  logic [SEQ_W-1:0]    seq, seq_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [DATA_W-1:0]   dat_q, dat_nxt;
  logic                valid_q, valid_nxt;
  logic                last_q, last_nxt;
  logic                busy_q, busy_nxt;
  logic                overrun_q, overrun_nxt;
  logic                pps_rise;

  // Frame index to scaler address: 32 contiguous L2/L3 words, then four aux words.
  function automatic logic [ADDR_W-1:0] addr_map(input logic [ADDR_W-1:0] i);
    case (i)
      6'd32:   addr_map = 6'h20;
      6'd33:   addr_map = 6'h21;
      6'd34:   addr_map = 6'h24;
      6'd35:   addr_map = 6'h25;
      default: addr_map = i;
    endcase
  endfunction

  assign pps_rise      = pps_i & ~pps_q;
  assign bus.scal_addr = addr_q;
  assign bus.dat       = dat_q;
  assign bus.valid     = valid_q;
  assign bus.last      = last_q;
  assign busy_o        = busy_q;
  assign overrun_o     = overrun_q;

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk33_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      pps_q     <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      seq       <= '0;
      addr_q    <= '0;
      dat_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      pps_q     <= pps_i;
      cnt_q     <= cnt_nxt;
      idx_q     <= idx_nxt;
      seq       <= seq_nxt;
      addr_q    <= addr_nxt;
      dat_q     <= dat_nxt;
      valid_q   <= valid_nxt;
      last_q    <= last_nxt;
      busy_q    <= busy_nxt;
      overrun_q <= overrun_nxt;
    end
  end

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt_q;
    idx_nxt     = idx_q;
    seq_nxt     = seq;
    addr_nxt    = addr_q;
    dat_nxt     = dat_q;
    valid_nxt   = valid_q;
    last_nxt    = last_q;
    busy_nxt    = busy_q;
    overrun_nxt = overrun_q;

    // A PPS that lands while a frame is running is dropped but remembered.
    if (pps_rise && (state != S_IDLE)) begin
      overrun_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (pps_rise && enable_i) begin
          cnt_nxt   = CNT_W'(SETTLE_CYCLES - 32'd1);
          busy_nxt  = 1'b1;
          state_nxt = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == '0) begin
          dat_nxt   = {HDR_TAG, overrun_q, 7'(NUM_DATA), seq};
          valid_nxt = 1'b1;
          idx_nxt   = '0;
          state_nxt = S_HDR;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end

      S_HDR: begin
        if (valid_q && bus.ready) begin
          seq_nxt     = seq + SEQ_W'(1);
          overrun_nxt = pps_rise;
          valid_nxt   = 1'b0;
          addr_nxt    = addr_map('0);
          state_nxt   = S_ADDR;
        end
      end

      // Address has been stable for a full cycle; capture the scaler word.
      S_ADDR: begin
        dat_nxt   = bus.scal_dat;
        valid_nxt = 1'b1;
        last_nxt  = (idx_q == LAST_IDX);
        state_nxt = S_PUSH;
      end

      S_PUSH: begin
        if (bus.ready) begin
          valid_nxt = 1'b0;
          if (idx_q == LAST_IDX) begin
            last_nxt  = 1'b0;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end else begin
            idx_nxt   = idx_q + ADDR_W'(1);
            addr_nxt  = addr_map(idx_q + ADDR_W'(1));
            state_nxt = S_ADDR;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_anita4_scaler_reader.sv
// Directed bench for anita4_scaler_reader with a frame scoreboard.
module tb_anita4_scaler_reader;

  localparam int unsigned SETTLE = 4;

  logic clk33;
  logic rst;
  logic pps;
  logic enable;
  logic busy;
  logic overrun;

  anita4_scaler_reader_if bus();

  // Scaler model: data is the address, combinationally.
  assign bus.scal_dat = {26'h0, bus.scal_addr};

  anita4_scaler_reader #(
    .SETTLE_CYCLES (SETTLE),
    .HDR_TAG       (8'h5C)
  ) dut (
    .clk33_i   (clk33),
    .rst_i     (rst),
    .pps_i     (pps),
    .enable_i  (enable),
    .bus       (bus),
    .busy_o    (busy),
    .overrun_o (overrun)
  );

  initial clk33 = 1'b0;
  always #15 clk33 = ~clk33;

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
    logic [5:0]  addr;
    logic        is_hdr;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;
  int          ready_pct = 100;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_dat;
  logic [5:0]  prev_addr;
  logic        prev_last;
  logic [5:0]  aux_addr [4] = '{6'h20, 6'h21, 6'h24, 6'h25};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Queue the 37 words a frame with this header must produce.
  task automatic push_frame(input logic [31:0] hdr);
    exp_t e;
    logic [5:0] a;
    e = '{dat: hdr, last: 1'b0, addr: 6'h0, is_hdr: 1'b1};
    exp_q.push_back(e);
    for (int k = 0; k < 36; k++) begin
      a = (k < 32) ? 6'(k) : aux_addr[k-32];
      e = '{dat: {26'h0, a}, last: (k == 35), addr: a, is_hdr: 1'b0};
      exp_q.push_back(e);
    end
  endtask

  // One cycle: check stall stability, drive ready, score any accepted word.
  task automatic tick();
    exp_t e;
    @(negedge clk33);
    if (stall_prev) begin
      check("stall_valid", 32'(bus.valid), 32'd1);
      check("stall_dat", bus.dat, prev_dat);
      check("stall_addr", 32'(bus.scal_addr), 32'(prev_addr));
      check("stall_last", 32'(bus.last), 32'(prev_last));
    end
    bus.ready = (int'($urandom_range(99)) < ready_pct);
    if (bus.valid && bus.ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", bus.dat, 32'hDEAD_0000);
      end else begin
        e = exp_q.pop_front();
        check(e.is_hdr ? "hdr_dat" : "word_dat", bus.dat, e.dat);
        check("word_last", 32'(bus.last), 32'(e.last));
        if (!e.is_hdr) check("word_addr", 32'(bus.scal_addr), 32'(e.addr));
      end
      accepted++;
    end
    stall_prev = bus.valid && !bus.ready;
    prev_dat   = bus.dat;
    prev_addr  = bus.scal_addr;
    prev_last  = bus.last;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 32'(bus.scal_addr), 32'd0);
    check({tag, "_dat"}, bus.dat, 32'd0);
    check({tag, "_valid"}, 32'(bus.valid), 32'd0);
    check({tag, "_last"}, 32'(bus.last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  // Start a frame with a PPS edge and run it, with optional mid-frame events
  // keyed to the number of words accepted so far (header counts as 1).
  task automatic run_frame(input logic [31:0] hdr, input int pct, input int pps2_at,
                           input int dis_at, input int rst_at, input logic exp_ovr);
    int n;
    int hdr_at;
    bit pps2_done;
    bit aborted;
    ready_pct = pct;
    accepted  = 0;
    n         = 0;
    hdr_at    = -1;
    pps2_done = 0;
    aborted   = 0;
    push_frame(hdr);
    pps = 1'b1;
    while (accepted < 37 && n < 3000) begin
      tick();
      n++;
      if (n == 1) check("busy_at_start", 32'(busy), 32'd1);
      if (n == 2) pps = 1'b0;
      if (hdr_at < 0 && bus.valid) hdr_at = n;
      if (pps2_at >= 0 && !pps2_done && accepted == pps2_at) begin
        pps = 1'b1;
        pps2_done = 1;
      end else if (pps2_done) begin
        pps = 1'b0;
      end
      if (dis_at >= 0 && accepted == dis_at) enable = 1'b0;
      if (rst_at >= 0 && accepted == rst_at) begin
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        stall_prev = 1'b0;
        pps = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        aborted = 1;
        break;
      end
    end
    check("hdr_latency", 32'(hdr_at), 32'(1 + SETTLE));
    if (!aborted) begin
      check("frame_words", 32'(accepted), 32'd37);
      tick();
      check("end_busy", 32'(busy), 32'd0);
      check("end_valid", 32'(bus.valid), 32'd0);
      check("end_last", 32'(bus.last), 32'd0);
      check("end_overrun", 32'(overrun), 32'(exp_ovr));
      check("end_queue", 32'(exp_q.size()), 32'd0);
    end
    pps    = 1'b0;
    enable = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    pps       = 1'b0;
    enable    = 1'b1;
    bus.ready = 1'b1;
    repeat (3) tick();
    check_all_zero("in_reset");
    rst = 1'b0;
    repeat (2) tick();
    check_all_zero("after_reset");

    // Basic frame, then the same sweep under backpressure.
    run_frame(32'h5C24_0000, 100, -1, -1, -1, 1'b0);
    run_frame(32'h5C24_0001, 70, -1, -1, -1, 1'b0);

    // Second PPS during data word 10; next header carries the overrun bit.
    run_frame(32'h5C24_0002, 100, 11, -1, -1, 1'b1);
    run_frame(32'h5CA4_0003, 100, -1, -1, -1, 1'b0);

    // PPS while disabled is ignored entirely.
    enable = 1'b0;
    pps    = 1'b1;
    tick();
    tick();
    pps = 1'b0;
    repeat (20) tick();
    check("disabled_busy", 32'(busy), 32'd0);
    check("disabled_overrun", 32'(overrun), 32'd0);
    check("disabled_queue", 32'(exp_q.size()), 32'd0);
    enable = 1'b1;
    repeat (2) tick();

    // Disable at data word 5 does not cut the frame short.
    run_frame(32'h5C24_0004, 50, -1, 6, -1, 1'b0);

    // Sequence counter wrap.
    force dut.seq_nxt = 16'hFFFF;
    tick();
    release dut.seq_nxt;
    tick();
    run_frame(32'h5C24_FFFF, 100, -1, -1, -1, 1'b0);
    run_frame(32'h5C24_0000, 100, -1, -1, -1, 1'b0);

    // Reset at data word 20, then a clean frame with seq restarted.
    run_frame(32'h5C24_0001, 100, -1, -1, 21, 1'b0);
    run_frame(32'h5C24_0000, 80, -1, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
